// File: rtl/jk_sync_counter.sv
// rtl/jk_sync_counter.sv - WIDTH-bit synchronous up/down counter built from JK flip-flop cells.
// Optional modulo-MOD wrapping is enabled by defining JK_CNT_MODN_EN.
module jk_sync_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc
);

`ifdef JK_CNT_MODN_EN
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);
`else
    localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};
`endif

    if (WIDTH < 2 || MOD < 2 || MOD > (1 << WIDTH)) begin : g_param_check
        $error("jk_sync_counter: WIDTH or MOD out of range");
    end

    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] q_next;
    logic             ones;
    logic             zeros;

    always_comb begin
        t     = '0;
        ones  = 1'b1;
        zeros = 1'b1;
        // Bit i toggles when all lower bits are 1 (up) or all 0 (down).
        for (int i = 0; i < WIDTH; i++) begin
            t[i]  = up ? ones : zeros;
            ones  = ones & q[i];
            zeros = zeros & ~q[i];
        end

        j = '0;
        k = '0;
        if (load) begin
            j = d;
            k = ~d;
        end else if (en) begin
`ifdef JK_CNT_MODN_EN
            // Out-of-range or wrapping values are forced with J/K set/clear pairs.
            if (up && q >= MAXV) begin
                j = '0;
                k = '1;
            end else if (!up && (q == '0 || q > MAXV)) begin
                j = MAXV;
                k = ~MAXV;
            end else begin
                j = t;
                k = t;
            end
`else
            j = t;
            k = t;
`endif
        end
    end

    assign q_next = (j & ~q) | (~k & q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q  <= '0;
            qb <= '1;
        end else begin
            q  <= q_next;
            qb <= ~q_next;
        end
    end

    assign tc = en & ~load & ((up & (q == MAXV)) | (~up & (q == '0)));

endmodule

// File: tb/tb_jk_sync_counter.sv
// tb/tb_jk_sync_counter.sv - directed self-checking bench for jk_sync_counter.
module tb_jk_sync_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic       up = 1'b1;
    logic [3:0] d = 4'h0;
    logic [3:0] q;
    logic [3:0] qb;
    logic       tc;

    int checks = 0;
    int errors = 0;

    jk_sync_counter #(.WIDTH(4), .MOD(10)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .load (load),
        .up   (up),
        .d    (d),
        .q    (q),
        .qb   (qb),
        .tc   (tc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        checks++;
        if (qb !== ~q) begin
            errors++;
            $display("FAIL qb_inv t=%0t q=%h qb=%h required qb=%h", $time, q, qb, ~q);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_q(input string name, input logic [3:0] exp);
        checks++;
        if (q !== exp) begin
            errors++;
            $display("FAIL %s q=%h required %h", name, q, exp);
        end
    endtask

    task automatic chk_tc(input string name, input logic exp);
        checks++;
        if (tc !== exp) begin
            errors++;
            $display("FAIL %s tc=%b required %b (q=%h)", name, tc, exp, q);
        end
    endtask

    task automatic test_reset;
        step();
        chk_q("reset_q", 4'h0);
        checks++;
        if (qb !== 4'hF) begin
            errors++;
            $display("FAIL reset_qb qb=%h required F", qb);
        end
        rst = 1'b0;
        step();
        chk_q("reset_release_hold", 4'h0);
    endtask

    task automatic test_count_up;
        en = 1'b1;
        up = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk_q("up_q", 4'(i));
            chk_tc("up_tc", i == 15);
            step();
        end
        chk_q("up_wrap", 4'h0);
    endtask

    task automatic test_load_down;
        logic [3:0] seq [4];
        seq = '{4'h3, 4'h2, 4'h1, 4'h0};
        en   = 1'b1;
        up   = 1'b0;
        load = 1'b1;
        d    = 4'h3;
        chk_tc("load_masks_tc", 1'b0);
        step();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_q("down_q", seq[i]);
            chk_tc("down_tc", seq[i] == 4'h0);
            step();
        end
        chk_q("down_wrap", 4'hF);
    endtask

    task automatic test_hold;
        load = 1'b1;
        d    = 4'h9;
        en   = 1'b0;
        step();
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            up = ~up;
            step();
            chk_q("hold_q", 4'h9);
            chk_tc("hold_tc", 1'b0);
        end
        load = 1'b1;
        en   = 1'b1;
        d    = 4'h5;
        step();
        load = 1'b0;
        en   = 1'b0;
        chk_q("load_over_en", 4'h5);
    endtask

    task automatic test_async_reset;
        load = 1'b1;
        d    = 4'h7;
        step();
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_q("async_rst_q", 4'h0);
        checks++;
        if (qb !== 4'hF) begin
            errors++;
            $display("FAIL async_rst_qb qb=%h required F", qb);
        end
        step();
        chk_q("rst_hold1", 4'h0);
        step();
        chk_q("rst_hold2", 4'h0);
        rst = 1'b0;
        step();
        chk_q("rst_resume", 4'h1);
        en = 1'b0;
    endtask

`ifdef JK_CNT_MODN_EN
    task automatic test_modn_count;
        load = 1'b1;
        d    = 4'h0;
        step();
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk_q("modn_up_q", 4'(i));
            chk_tc("modn_up_tc", i == 9);
            step();
        end
        chk_q("modn_up_wrap", 4'h0);
        up = 1'b0;
        chk_tc("modn_down_tc", 1'b1);
        step();
        chk_q("modn_down_wrap", 4'h9);
        en = 1'b0;
    endtask

    task automatic test_modn_load;
        load = 1'b1;
        d    = 4'hC;
        step();
        chk_q("modn_load12", 4'hC);
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        step();
        chk_q("modn_over_up", 4'h0);
        load = 1'b1;
        step();
        load = 1'b0;
        up   = 1'b0;
        step();
        chk_q("modn_over_down", 4'h9);
        en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_count_up();
        test_load_down();
        test_hold();
        test_async_reset();
`ifdef JK_CNT_MODN_EN
        test_modn_count();
        test_modn_load();
`endif
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
